// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel position, active-video and line/frame flags,
// plus hsync/vsync delayed through a short pipe to line up with registered colour.
module vga_timing_gen #(
  parameter int H_VIDEO    = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VIDEO    = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clk_0,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VIDEO + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIDEO + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VID    = 10'(H_VIDEO);
  localparam logic [9:0] V_VID    = 10'(V_VIDEO);
  localparam logic [9:0] HS_START = 10'(H_VIDEO + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VIDEO + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIDEO + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VIDEO + V_FRONT + V_SYNC);

  localparam logic H_ACT  = 1'(H_SYNC_POL);
  localparam logic V_ACT  = 1'(V_SYNC_POL);
  localparam logic H_IDLE = ~H_ACT;
  localparam logic V_IDLE = ~V_ACT;

  logic [9:0] h_q, v_q, h_d, v_d;
  logic [9:0] px_q, py_q;
  logic       von_q, ls_q, fs_q, first_q;
  logic       von_d, ls_d, fs_d, hs_d, vs_d;
  logic [7:0] fc_q;
  // sync_q[0] is aligned with pixel_x; each further entry adds one cycle of delay
  logic [1:0] sync_q [SYNC_DELAY+1];

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
    von_d = (h_d < H_VID) && (v_d < V_VID);
    ls_d  = (h_d == '0);
    fs_d  = ls_d && (v_d == '0);
    hs_d  = (h_d >= HS_START && h_d < HS_END) ? H_ACT : H_IDLE;
    vs_d  = (v_d >= VS_START && v_d < VS_END) ? V_ACT : V_IDLE;
  end

  // Counters park at the last position in reset so the first free-running edge lands on (0,0)
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      px_q    <= '0;
      py_q    <= '0;
      von_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
      first_q <= 1'b1;
      for (int i = 0; i <= SYNC_DELAY; i++) sync_q[i] <= {V_IDLE, H_IDLE};
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      px_q  <= h_d;
      py_q  <= v_d;
      von_q <= von_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      if (fs_d) begin
        if (first_q) first_q <= 1'b0;
        else         fc_q    <= fc_q + 8'd1;
      end
      sync_q[0] <= {vs_d, hs_d};
      for (int i = 1; i <= SYNC_DELAY; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign video_on    = von_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;
  assign hsync       = sync_q[SYNC_DELAY][0];
  assign vsync       = sync_q[SYNC_DELAY][1];

endmodule
